// File: rtl/crank_cam_gen.sv
// 60-2 style crank tooth (vr) and cam phase generator. Tooth period is
// runtime-programmable with an optional signed per-tooth ramp.
module crank_cam_gen #(
  parameter int unsigned TEETH      = 58,
  parameter int unsigned MISSING    = 2,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned DEF_PERIOD = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_ld,
  input  logic [7:0]          period_step,
  input  logic [5:0]          cam_on,
  input  logic [5:0]          cam_off,
  output logic                vr,
  output logic                cam,
  output logic [5:0]          tooth_idx,
  output logic                cam_phase,
  output logic                rev_stb
);

  localparam int unsigned CntW = PERIOD_W + 2;
  localparam logic [5:0] LastIdx = 6'(TEETH - 1);
  localparam logic signed [CntW-1:0] MinS = CntW'(MIN_PERIOD);
  localparam logic signed [CntW-1:0] MaxS = CntW'((1 << PERIOD_W) - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [5:0]          tooth_q, tooth_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic                ld_pend_q, ld_pend_d;
  logic                vr_q, vr_d;
  logic                cam_q, cam_d;
  logic                phase_q, phase_d;
  logic                rev_q, rev_d;

  logic [CntW-1:0]        len, half;
  logic                   slot_end, last_tooth;
  logic signed [CntW-1:0] ramp_sum;
  logic [PERIOD_W-1:0]    ramp_val, load_val;

  always_comb begin
    last_tooth = (tooth_q == LastIdx);
    // The last real tooth's slot also spans the missing-tooth gap.
    len = last_tooth ? CntW'(cur_period_q) * CntW'(MISSING + 1) : CntW'(cur_period_q);
    half     = len >> 1;
    slot_end = (cnt_q == len - CntW'(1));

    // Two extra bits keep the sum from wrapping near the top of the range.
    ramp_sum = $signed({2'b00, cur_period_q}) + CntW'($signed(period_step));
    if (ramp_sum < MinS)      ramp_val = PERIOD_W'(MIN_PERIOD);
    else if (ramp_sum > MaxS) ramp_val = PERIOD_W'(MaxS);
    else                      ramp_val = PERIOD_W'(ramp_sum);
    load_val = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
  end

  always_comb begin
    cnt_d        = cnt_q;
    tooth_d      = tooth_q;
    cur_period_d = cur_period_q;
    ld_pend_d    = ld_pend_q | period_ld;
    vr_d         = vr_q;
    cam_d        = cam_q;
    phase_d      = phase_q;
    rev_d        = 1'b0;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        vr_d  = 1'b0;
        if (last_tooth) begin
          tooth_d = '0;
          phase_d = ~phase_q;
          rev_d   = 1'b1;
        end else begin
          tooth_d = tooth_q + 6'd1;
        end
        if (ld_pend_q) begin
          cur_period_d = load_val;
          // A load arriving in this same cycle stays pending for the next slot.
          ld_pend_d    = period_ld;
        end else begin
          cur_period_d = ramp_val;
        end
        if (phase_d) begin
          if (tooth_d == cam_off)     cam_d = 1'b0;
          else if (tooth_d == cam_on) cam_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
        vr_d  = (cnt_q + CntW'(1)) >= half;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      tooth_q      <= '0;
      cur_period_q <= PERIOD_W'(DEF_PERIOD);
      ld_pend_q    <= 1'b0;
      vr_q         <= 1'b0;
      cam_q        <= 1'b0;
      phase_q      <= 1'b0;
      rev_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tooth_q      <= tooth_d;
      cur_period_q <= cur_period_d;
      ld_pend_q    <= ld_pend_d;
      vr_q         <= vr_d;
      cam_q        <= cam_d;
      phase_q      <= phase_d;
      rev_q        <= rev_d;
    end
  end

  assign vr        = vr_q;
  assign cam       = cam_q;
  assign tooth_idx = tooth_q;
  assign cam_phase = phase_q;
  assign rev_stb   = rev_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Randomized bench for crank_cam_gen against a slot-position reference model.
module tb_crank_cam_gen;

  localparam int Teeth   = 58;
  localparam int Missing = 2;
  localparam int MinP    = 4;
  localparam int MaxP    = 65535;
  localparam int DefP    = 64;

  logic        clk = 1'b0;
  logic        rst, en, period_ld;
  logic [15:0] period;
  logic [7:0]  period_step;
  logic [5:0]  cam_on, cam_off;
  logic        vr, cam, cam_phase, rev_stb;
  logic [5:0]  tooth_idx;

  crank_cam_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period     (period),
    .period_ld  (period_ld),
    .period_step(period_step),
    .cam_on     (cam_on),
    .cam_off    (cam_off),
    .vr         (vr),
    .cam        (cam),
    .tooth_idx  (tooth_idx),
    .cam_phase  (cam_phase),
    .rev_stb    (rev_stb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rev = -1;
  bit track_rev = 1'b0;

  // Reference state: position within the current slot, tooth, period, etc.
  int m_pos, m_tooth, m_per, m_pend, m_phase, m_cam, m_rev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_len();
    return (m_tooth == Teeth - 1) ? m_per * (Missing + 1) : m_per;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_tooth = 0; m_per = DefP; m_pend = 0;
    m_phase = 0; m_cam = 0; m_rev = 0;
  endtask

  task automatic model_edge();
    int nv;
    m_rev = 0;
    if (en) begin
      if (m_pos == m_len() - 1) begin
        m_pos = 0;
        if (m_tooth == Teeth - 1) begin
          m_tooth = 0;
          m_phase = 1 - m_phase;
          m_rev = 1;
        end else begin
          m_tooth++;
        end
        if (m_pend != 0) begin
          m_per  = (int'(period) < MinP) ? MinP : int'(period);
          m_pend = 0;
        end else begin
          nv = m_per + int'($signed(period_step));
          m_per = (nv < MinP) ? MinP : (nv > MaxP) ? MaxP : nv;
        end
        if (m_phase == 1) begin
          if (m_tooth == int'(cam_off))     m_cam = 0;
          else if (m_tooth == int'(cam_on)) m_cam = 1;
        end
      end else begin
        m_pos++;
      end
    end
    if (period_ld) m_pend = 1;
  endtask

  task automatic compare_all();
    check_eq("vr", 32'(vr), 32'(m_pos >= m_len() / 2));
    check_eq("cam", 32'(cam), 32'(m_cam));
    check_eq("tooth_idx", 32'(tooth_idx), 32'(m_tooth));
    check_eq("cam_phase", 32'(cam_phase), 32'(m_phase));
    check_eq("rev_stb", 32'(rev_stb), 32'(m_rev));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    cyc++;
    compare_all();
    if (track_rev && rev_stb) begin
      check_eq("rev_interval", 32'(cyc - last_rev), 32'd3840);
      last_rev = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int p);
    period = 16'(p);
    period_ld = 1'b1;
    tick();
    period_ld = 1'b0;
  endtask

  initial begin
    int k;
    int r;
    rst = 1'b1; en = 1'b0; period_ld = 1'b0; period = 16'd64;
    period_step = 8'd0; cam_on = 6'd4; cam_off = 6'd54;
    model_reset();
    run(3);
    check_eq("rst_vr", 32'(vr), 32'd0);
    check_eq("rst_tooth", 32'(tooth_idx), 32'd0);
    check_eq("rst_rev", 32'(rev_stb), 32'd0);

    // Default period, cam window on teeth 4..53 of odd revolutions.
    rst = 1'b0; en = 1'b1;
    last_rev = cyc; track_rev = 1'b1;
    run(8000);
    track_rev = 1'b0;

    // Equal on/off indices: off wins, cam never rises.
    cam_on = 6'd10; cam_off = 6'd10;
    run(4000);

    // Ramp up, then clamp down to the minimum period.
    period_step = 8'd1;
    run(600);
    period_step = 8'h80;
    load(100);
    run(1500);
    period_step = 8'd0;
    load(1);
    run(300);

    // Random enable, loads, ramps and cam window.
    for (int i = 0; i < 20000; i++) begin
      if (i % 200 == 0) begin
        r = int'($urandom_range(0, 4));
        period_step = 8'(r - 2);
      end
      if (i % 3000 == 0) begin
        cam_on  = 6'($urandom_range(0, 63));
        cam_off = 6'($urandom_range(0, 63));
      end
      en = ($urandom_range(0, 15) != 0);
      period_ld = ($urandom_range(0, 63) == 0);
      period = 16'($urandom_range(0, 24));
      tick();
    end
    en = 1'b1; period_ld = 1'b0; period_step = 8'd0;

    // Freeze in the middle of the gap slot.
    load(20);
    run(1500);
    k = 0;
    while (!(tooth_idx == 6'd57) && k < 5000) begin tick(); k++; end
    check_eq("wait_gap", 32'(k < 5000), 32'd1);
    run(40);
    en = 1'b0;
    run(500);
    en = 1'b1;
    run(300);

    // Asynchronous reset in the gap while cam is high, with a load pending.
    cam_on = 6'd4; cam_off = 6'd63;
    k = 0;
    while (!(tooth_idx == 6'd57 && cam == 1'b1) && k < 6000) begin tick(); k++; end
    check_eq("wait_cam_gap", 32'(k < 6000), 32'd1);
    run(5);
    load(30);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_vr", 32'(vr), 32'd0);
    check_eq("arst_cam", 32'(cam), 32'd0);
    check_eq("arst_tooth", 32'(tooth_idx), 32'd0);
    check_eq("arst_phase", 32'(cam_phase), 32'd0);
    check_eq("arst_rev", 32'(rev_stb), 32'd0);
    model_reset();
    run(2);
    rst = 1'b0;
    run(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
